multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have the port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port opcode, input, 3 bits: instruction bits [7:5], valid in DECODE.
REQ-004 The block SHALL have the port zero, input, 1 bit: register-file zero test, sampled in EXEC.
REQ-005 The block SHALL have the port mem_ready, input, 1 bit: memory handshake completion.
REQ-006 The block SHALL have the port pc_write, output, 1 bit: PC load strobe.
REQ-007 The block SHALL have the port pc_sel, output, 2 bits: 0=PC+1, 1=branch target.
REQ-008 The block SHALL have the port ir_write, output, 1 bit: instruction register load.
REQ-009 The block SHALL have the ports mem_read and mem_write, outputs, 1 bit each: memory strobes.
REQ-010 The block SHALL have the port alu_op, output, 2 bits: 0=ADD, 1=SUB, 2=AND.
REQ-011 The block SHALL have the port wb_sel, output, 2 bits: drives the registered 3:1 writeback mux (0=ALU, 1=memory data, 2=immediate).
REQ-012 The block SHALL have the port reg_write, output, 1 bit: register-file write strobe.
REQ-013 The block SHALL have the port halted, output, 1 bit: high in HALT.
REQ-014 The block SHALL have the port retired, output, 8 bits: count of retired instructions.

Function
REQ-015 Opcode map SHALL be: 000 ADD, 001 SUB, 010 AND, 011 LOAD, 100 STORE, 101 LI, 110 BEQZ, 111 HALT.
REQ-016 States SHALL be FETCH, DECODE, EXEC, MEM, WB_SEL, WB, HALT; outputs are decoded from the state register and the latched opcode (opcode_q).
REQ-017 FETCH SHALL assert mem_read, and SHALL assert ir_write and pc_write (pc_sel=0) only in the cycle mem_ready=1, then go to DECODE; with mem_ready=0 it holds FETCH.
REQ-018 DECODE SHALL latch opcode into opcode_q and go to HALT if opcode=111, else to EXEC.
REQ-019 EXEC SHALL drive alu_op per opcode_q (SUB for BEQZ, 0 otherwise), and SHALL transition as follows: ALU ops go to WB_SEL; LOAD and STORE go to MEM; LI goes to WB_SEL.
REQ-020 EXEC with BEQZ SHALL assert pc_write with pc_sel=1 when zero=1 (no write when zero=0), then go to FETCH.
REQ-021 MEM SHALL assert mem_read (LOAD) or mem_write (STORE) until mem_ready=1; on that cycle LOAD goes to WB_SEL and STORE goes to FETCH.
REQ-022 WB_SEL and WB SHALL both hold wb_sel (ALU ops 0, LOAD 1, LI 2) so the registered mux output is valid one cycle before the write.
REQ-023 reg_write SHALL be asserted only in WB, for exactly one cycle; WB then goes to FETCH.
REQ-024 HALT SHALL be absorbing, with halted=1 and all strobes 0, until reset.
REQ-025 In any state not listed, all strobes, alu_op, pc_sel and wb_sel SHALL be 0.
REQ-026 An instruction SHALL retire on the transition into FETCH from EXEC (BEQZ), MEM (STORE) or WB; HALT does not retire.
REQ-027 Latency in cycles SHALL be, with mem_ready tied high: ALU/LI 5, LOAD 6, STORE 4, BEQZ 3.

Reset
REQ-028 A reset sampled high SHALL put the block in FETCH with opcode_q=0 and retired=0.
REQ-029 All strobes SHALL be forced to 0 in every cycle reset is high.
REQ-030 Reset mid-instruction (including mid-handshake or in HALT) SHALL abort the instruction without a retire count.

Configuration
REQ-031 With INSTR_COUNT_EN defined, retired SHALL increment by 1 per retire and wrap from 255 to 0.
REQ-032 Without INSTR_COUNT_EN, retired SHALL be constant 0 and no counter register SHALL be present.

Verification
REQ-033 The bench SHALL run ADD with mem_ready=1 -> states FETCH,DECODE,EXEC,WB_SEL,WB; wb_sel=0 in cycles 4-5; reg_write=1 only in cycle 5.
REQ-034 The bench SHALL run LOAD with mem_ready low for 3 cycles in MEM -> mem_read held 4 cycles; then wb_sel=1, one reg_write pulse.
REQ-035 The bench SHALL run BEQZ with zero=1 and then zero=0 -> pc_write=1 with pc_sel=1 in EXEC for the first, no pc_write in EXEC for the second.
REQ-036 The bench SHALL run HALT -> halted=1 for 20 cycles with all strobes 0; reset -> FETCH, halted=0.
REQ-037 The bench SHALL assert reset during a STORE in MEM -> no mem_write after the reset edge, retired unchanged, state FETCH.
REQ-038 The bench SHALL run 256 LI instructions with INSTR_COUNT_EN defined -> retired wraps to 0; without the macro, retired stays 0 throughout.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller (master) and its datapath (slave):
// instruction/status inputs to the controller and the strobes it drives.
interface multicycle_control_if;
  logic [2:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic [1:0] pc_sel;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] alu_op;
  logic [1:0] wb_sel;
  logic       reg_write;
  logic       halted;
  logic [7:0] retired;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, pc_sel, ir_write, mem_read, mem_write,
           alu_op, wb_sel, reg_write, halted, retired
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, pc_sel, ir_write, mem_read, mem_write,
           alu_op, wb_sel, reg_write, halted, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle CPU control FSM (FETCH/DECODE/EXEC/MEM/WB_SEL/WB/HALT).
// Optional retired-instruction counter enabled by defining INSTR_COUNT_EN.
module multicycle_control (
  input  logic                 clock,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB_SEL = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_AND   = 3'b010;
  localparam logic [2:0] OP_LOAD  = 3'b011;
  localparam logic [2:0] OP_STORE = 3'b100;
  localparam logic [2:0] OP_LI    = 3'b101;
  localparam logic [2:0] OP_BEQZ  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  state_e     state_q, state_d;
  logic [2:0] opcode_q, opcode_d;

  // Writeback source: the mux is registered, so WB_SEL and WB present the same select.
  function automatic logic [1:0] wb_sel_of(input logic [2:0] op);
    case (op)
      OP_LOAD: wb_sel_of = 2'd1;
      OP_LI:   wb_sel_of = 2'd2;
      default: wb_sel_of = 2'd0;
    endcase
  endfunction

  // State and latched-opcode registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_FETCH;
      opcode_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    case (state_q)
      S_FETCH: begin
        if (bus.mem_ready) state_d = S_DECODE;
        else               state_d = S_FETCH;
      end
      S_DECODE: begin
        opcode_d = bus.opcode;
        if (bus.opcode == OP_HALT) state_d = S_HALT;
        else                       state_d = S_EXEC;
      end
      S_EXEC: begin
        case (opcode_q)
          OP_ADD, OP_SUB, OP_AND, OP_LI: state_d = S_WB_SEL;
          OP_LOAD, OP_STORE:             state_d = S_MEM;
          default:                       state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (!bus.mem_ready)            state_d = S_MEM;
        else if (opcode_q == OP_LOAD)  state_d = S_WB_SEL;
        else                           state_d = S_FETCH;
      end
      S_WB_SEL: state_d = S_WB;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode from state_q/opcode_q; reset masks every output combinationally
  always_comb begin
    bus.pc_write  = 1'b0;
    bus.pc_sel    = 2'd0;
    bus.ir_write  = 1'b0;
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.alu_op    = 2'd0;
    bus.wb_sel    = 2'd0;
    bus.reg_write = 1'b0;
    bus.halted    = 1'b0;
    if (reset) begin
      bus.halted = 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          bus.mem_read = 1'b1;
          bus.ir_write = bus.mem_ready;
          bus.pc_write = bus.mem_ready;
        end
        S_EXEC: begin
          case (opcode_q)
            OP_SUB, OP_BEQZ: bus.alu_op = 2'd1;
            OP_AND:          bus.alu_op = 2'd2;
            default:         bus.alu_op = 2'd0;
          endcase
          if ((opcode_q == OP_BEQZ) && bus.zero) begin
            bus.pc_write = 1'b1;
            bus.pc_sel   = 2'd1;
          end else begin
            bus.pc_write = 1'b0;
          end
        end
        S_MEM: begin
          bus.mem_read  = (opcode_q == OP_LOAD);
          bus.mem_write = (opcode_q == OP_STORE);
        end
        S_WB_SEL: bus.wb_sel = wb_sel_of(opcode_q);
        S_WB: begin
          bus.wb_sel    = wb_sel_of(opcode_q);
          bus.reg_write = 1'b1;
        end
        S_HALT:  bus.halted = 1'b1;
        default: bus.halted = 1'b0;
      endcase
    end
  end

`ifdef INSTR_COUNT_EN
  logic       retire_s;
  logic [7:0] retired_q, retired_d;

  // Retire on entry to FETCH from the last state of an instruction
  always_comb begin
    retire_s  = (state_d == S_FETCH) &&
                ((state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB));
    retired_d = retire_s ? (retired_q + 8'd1) : retired_q;
  end

  // Retired-instruction counter, wraps naturally at 8 bits
  always_ff @(posedge clock) begin
    if (reset) retired_q <= 8'd0;
    else       retired_q <= retired_d;
  end

  assign bus.retired = retired_q;
`else
  assign bus.retired = 8'd0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for multicycle_control; expected values hand-computed.
module tb_multicycle_control;
  logic clock;
  logic reset;
  multicycle_control_if bus ();

  multicycle_control dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, S = 3'd4, W = 3'd5, H = 3'd6;
  // Output bundle: {pc_write, pc_sel[1:0], ir_write, mem_read, mem_write, alu_op[1:0], wb_sel[1:0], reg_write, halted}
  localparam logic [11:0] O_NONE  = 12'h000;
  localparam logic [11:0] O_FETCH = 12'h980;
  localparam logic [11:0] O_FWAIT = 12'h080;
  localparam logic [11:0] O_SUB   = 12'h010;
  localparam logic [11:0] O_AND   = 12'h020;
  localparam logic [11:0] O_TAKEN = 12'hA10;
  localparam logic [11:0] O_MRD   = 12'h080;
  localparam logic [11:0] O_MWR   = 12'h040;
  localparam logic [11:0] O_WBS1  = 12'h004;
  localparam logic [11:0] O_WBS2  = 12'h008;
  localparam logic [11:0] O_WB0   = 12'h002;
  localparam logic [11:0] O_WB1   = 12'h006;
  localparam logic [11:0] O_WB2   = 12'h00A;
  localparam logic [11:0] O_HALT  = 12'h001;

  typedef struct {
    logic [2:0]  op;
    logic        z;
    logic        rdy;
    logic        rst;
    logic [2:0]  st;
    logic [11:0] outs;
  } vec_t;

  vec_t       vq[$];
  int         errors = 0;
  int         checks = 0;
  int         model  = 0;
  logic [2:0] prev_st = F;
  int         row_no = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (row %0d): got 0x%0h expected 0x%0h", name, row_no, act, exp);
    end
  endtask

  task automatic add(input logic [2:0] op, input logic z, input logic rdy, input logic rst,
                     input logic [2:0] st, input logic [11:0] outs);
    vec_t v;
    v.op = op; v.z = z; v.rdy = rdy; v.rst = rst; v.st = st; v.outs = outs;
    vq.push_back(v);
  endtask

  function automatic logic [7:0] exp_retired(input int m);
`ifdef INSTR_COUNT_EN
    exp_retired = 8'(m);
`else
    exp_retired = 8'd0;
`endif
  endfunction

  // One cycle: drive inputs, check at falling edge, then advance past the rising edge
  task automatic row(input logic [2:0] op, input logic z, input logic rdy, input logic rst,
                     input logic [2:0] st, input logic [11:0] outs);
    logic [11:0] act;
    bus.opcode = op; bus.zero = z; bus.mem_ready = rdy; reset = rst;
    if ((st == F) && ((prev_st == E) || (prev_st == M) || (prev_st == W))) model++;
    @(negedge clock);
    act = {bus.pc_write, bus.pc_sel, bus.ir_write, bus.mem_read, bus.mem_write,
           bus.alu_op, bus.wb_sel, bus.reg_write, bus.halted};
    chk("state", 32'(dut.state_q), 32'(st));
    chk("outputs", 32'(act), 32'(outs));
    chk("retired", 32'(bus.retired), 32'(exp_retired(model)));
    if (rst) begin
      model   = 0;
      prev_st = F;
    end else begin
      prev_st = st;
    end
    row_no++;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.opcode = 3'd0; bus.zero = 1'b0; bus.mem_ready = 1'b1; reset = 1'b1;
    @(posedge clock);
    #1;
    model = 0;
    prev_st = F;
  endtask

  initial begin
    do_reset();
    // second reset cycle: FETCH with mem_ready=1 must still show no strobes
    row(3'd0, 1'b0, 1'b1, 1'b1, F, O_NONE);
    chk("opcode_q_after_reset", 32'(dut.opcode_q), 32'd0);

    // ADD (with one FETCH wait), SUB, AND, LI
    add(3'd0, 0, 0, 0, F, O_FWAIT);
    add(3'd0, 0, 1, 0, F, O_FETCH); add(3'b000, 0, 1, 0, D, O_NONE);
    add(3'b000, 0, 1, 0, E, O_NONE); add(3'b000, 0, 1, 0, S, O_NONE); add(3'b000, 0, 1, 0, W, O_WB0);
    add(3'd0, 0, 1, 0, F, O_FETCH); add(3'b001, 0, 1, 0, D, O_NONE);
    add(3'b001, 0, 1, 0, E, O_SUB);  add(3'b001, 0, 1, 0, S, O_NONE); add(3'b001, 0, 1, 0, W, O_WB0);
    add(3'd0, 0, 1, 0, F, O_FETCH); add(3'b010, 0, 1, 0, D, O_NONE);
    add(3'b010, 0, 1, 0, E, O_AND);  add(3'b010, 0, 1, 0, S, O_NONE); add(3'b010, 0, 1, 0, W, O_WB0);
    add(3'd0, 0, 1, 0, F, O_FETCH); add(3'b101, 0, 1, 0, D, O_NONE);
    add(3'b101, 0, 1, 0, E, O_NONE); add(3'b101, 0, 1, 0, S, O_WBS2); add(3'b101, 0, 1, 0, W, O_WB2);
    // LOAD with three stalled MEM cycles
    add(3'd0, 0, 1, 0, F, O_FETCH); add(3'b011, 0, 1, 0, D, O_NONE); add(3'b011, 0, 1, 0, E, O_NONE);
    add(3'b011, 0, 0, 0, M, O_MRD);  add(3'b011, 0, 0, 0, M, O_MRD);  add(3'b011, 0, 0, 0, M, O_MRD);
    add(3'b011, 0, 1, 0, M, O_MRD);  add(3'b011, 0, 1, 0, S, O_WBS1); add(3'b011, 0, 1, 0, W, O_WB1);
    // STORE, BEQZ taken, BEQZ not taken
    add(3'd0, 0, 1, 0, F, O_FETCH); add(3'b100, 0, 1, 0, D, O_NONE); add(3'b100, 0, 1, 0, E, O_NONE);
    add(3'b100, 0, 1, 0, M, O_MWR);
    add(3'd0, 0, 1, 0, F, O_FETCH); add(3'b110, 0, 1, 0, D, O_NONE); add(3'b110, 1, 1, 0, E, O_TAKEN);
    add(3'd0, 0, 1, 0, F, O_FETCH); add(3'b110, 0, 1, 0, D, O_NONE); add(3'b110, 0, 1, 0, E, O_SUB);
    add(3'd0, 0, 0, 0, F, O_FWAIT);

    foreach (vq[i]) row(vq[i].op, vq[i].z, vq[i].rdy, vq[i].rst, vq[i].st, vq[i].outs);

    // Reset while STORE is waiting in MEM: no mem_write afterwards, no retire
    row(3'd0, 0, 1, 0, F, O_FETCH); row(3'b100, 0, 1, 0, D, O_NONE); row(3'b100, 0, 1, 0, E, O_NONE);
    row(3'b100, 0, 0, 0, M, O_MWR);
    row(3'b100, 0, 1, 1, M, O_NONE);
    row(3'b100, 0, 0, 0, F, O_FWAIT);
    chk("opcode_q_after_mid_reset", 32'(dut.opcode_q), 32'd0);

    // HALT is absorbing for 20 cycles, then reset returns to FETCH
    row(3'd0, 0, 1, 0, F, O_FETCH); row(3'b111, 0, 1, 0, D, O_NONE);
    for (int k = 0; k < 20; k++)
      row(3'($urandom_range(0, 7)), 1'(k % 2), 1'b1, 1'b0, H, O_HALT);
    row(3'd0, 0, 1, 1, H, O_NONE);
    row(3'd0, 0, 0, 0, F, O_FWAIT);

    // 256 LI instructions from a fresh reset: counter wraps back to 0 if enabled
    row(3'd0, 0, 1, 1, F, O_NONE);
    for (int k = 0; k < 256; k++) begin
      row(3'd0, 0, 1, 0, F, O_FETCH); row(3'b101, 0, 1, 0, D, O_NONE); row(3'b101, 0, 1, 0, E, O_NONE);
      row(3'b101, 0, 1, 0, S, O_WBS2); row(3'b101, 0, 1, 0, W, O_WB2);
    end
    row(3'd0, 0, 0, 0, F, O_FWAIT);
    chk("retired_after_256_li", 32'(bus.retired), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
